// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width
// and the nibble counter sizing helper.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Counter must index WIDTH/4 nibbles; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead adder, purely combinational. Carries are expanded
// from generate/propagate terms rather than rippled.
module nibble_serial_adder_cla
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carry equations, each carry from g/p and cin only.
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    end

    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_sum
        assign s[gi] = p[gi] ^ c[gi];
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: operands are accepted whole, then pushed
// through a single 4-bit CLA one nibble per cycle, LSB nibble first, with
// the carry held in a register between slices.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t            state_reg;
    logic [WIDTH-1:0]  a_sh_reg;
    logic [WIDTH-1:0]  b_sh_reg;
    logic [WIDTH-1:0]  sum_sh_reg;
    logic              carry_reg;
    logic              sign_a_reg;
    logic              sign_b_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              out_valid_reg;
    logic              ovf_reg;

    logic [NIBBLE_W-1:0] cla_s;
    logic                cla_cout;
    logic [WIDTH-1:0]    sum_next;
    logic                accept;

    nibble_serial_adder_cla u_cla (
        .a    (a_sh_reg[NIBBLE_W-1:0]),
        .b    (b_sh_reg[NIBBLE_W-1:0]),
        .cin  (carry_reg),
        .s    (cla_s),
        .cout (cla_cout)
    );

    // Ready is combinational on out_ready so a result can be drained and a
    // new operation accepted in the same cycle.
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // New slice enters at the top; after NIBBLES shifts the first slice sits
    // at bit 0. Width casts keep this valid for WIDTH == 4.
    assign sum_next = (sum_sh_reg >> NIBBLE_W) | (WIDTH'(cla_s) << (WIDTH - NIBBLE_W));

    // Control FSM plus all datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_sh_reg    <= '0;
            carry_reg     <= 1'b0;
            sign_a_reg    <= 1'b0;
            sign_b_reg    <= 1'b0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (accept) begin
            a_sh_reg      <= a;
            b_sh_reg      <= b;
            carry_reg     <= cin;
            sign_a_reg    <= a[WIDTH-1];
            sign_b_reg    <= b[WIDTH-1];
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            state_reg     <= RUN;
        end else begin
            case (state_reg)
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> NIBBLE_W;
                    b_sh_reg   <= b_sh_reg >> NIBBLE_W;
                    sum_sh_reg <= sum_next;
                    carry_reg  <= cla_cout;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        // Final slice produces the sum MSB, so overflow is
                        // decided here from the captured operand signs.
                        ovf_reg       <= (sign_a_reg == sign_b_reg) && (cla_s[NIBBLE_W-1] != sign_a_reg);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_sh_reg;
    assign cout      = carry_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 16-bit and a 4-bit instance, checked
// against plain integer arithmetic for sum, carry-out and signed overflow.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from integer addition of two 16-bit values.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        int unsigned full;
        logic [15:0] s;
        logic        o;
        full = int'(x) + int'(y) + int'(c);
        s    = full[15:0];
        o    = ($signed(x) + $signed(y) + int'(c) > 32767) || ($signed(x) + $signed(y) + int'(c) < -32768);
        return {o, full[16], s};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int full;
        int sv;
        full = int'(x) + int'(y) + int'(c);
        sv   = int'($signed(x)) + int'($signed(y)) + int'(c);
        return {(sv > 7 || sv < -8), full[4], full[3:0]};
    endfunction

    // Present one operation on the 16-bit instance and hold it for one edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid; bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    task automatic drain;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b expected 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        $display("reset: in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, sum);
    endtask

    task automatic test_directed;
        logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] vb [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h8000};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [17:0] req [4] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b11, 16'h0000}};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i], vc[i]);
            wait_done(cyc);
            checks++;
            if (cyc != 4) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles expected 4", i, cyc);
            end
            checks++;
            if ({ovf, cout, sum} !== req[i] || {ovf, cout, sum} !== model16(va[i], vb[i], vc[i])) begin
                errors++;
                $display("FAIL directed[%0d]: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                         i, ovf, cout, sum, req[i][17], req[i][16], req[i][15:0]);
            end
            $display("directed %h+%h+%b -> sum=%h cout=%b ovf=%b lat=%0d", va[i], vb[i], vc[i], sum, cout, ovf, cyc);
            drain();
        end
    endtask

    task automatic test_random;
        logic [15:0] x, y;
        logic        c;
        logic [17:0] exp_v;
        int cyc;
        for (int i = 0; i < 24; i++) begin
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
            exp_v = model16(x, y, c);
            send(x, y, c);
            // Inputs must be ignored while running.
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            wait_done(cyc);
            checks++;
            if (cyc != 4 || {ovf, cout, sum} !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got ovf=%b cout=%b sum=%h lat=%0d expected ovf=%b cout=%b sum=%h lat=4",
                         i, ovf, cout, sum, cyc, exp_v[17], exp_v[16], exp_v[15:0]);
            end
            $display("random %h+%h+%b -> sum=%h cout=%b ovf=%b", x, y, c, sum, cout, ovf);
            drain();
        end
    endtask

    task automatic test_backpressure;
        logic [17:0] held;
        logic [17:0] exp_v;
        int cyc;
        send(16'hA5A5, 16'h5A5B, 1'b0);
        wait_done(cyc);
        held = {ovf, cout, sum};
        exp_v = model16(16'hA5A5, 16'h5A5B, 1'b0);
        checks++;
        if (held !== exp_v) begin
            errors++;
            $display("FAIL bp_result: got %h expected %h", held, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== held) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b val=%h expected 1 0 %h",
                         i, out_valid, in_ready, {ovf, cout, sum}, held);
            end
        end
        // Drain and accept in the same cycle.
        a = 16'h0F0F; b = 16'hF0F0; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_same_cycle_ready: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc != 4 || {ovf, cout, sum} !== {2'b01, 16'h0000}) begin
            errors++;
            $display("FAIL bp_back_to_back: got ovf=%b cout=%b sum=%h lat=%0d expected 0 1 0000 lat=4",
                     ovf, cout, sum, cyc);
        end
        $display("backpressure: next sum=%h cout=%b ovf=%b lat=%0d", sum, cout, ovf, cyc);
        drain();
    endtask

    task automatic test_reset_mid;
        int cyc;
        send(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_async: out_valid=%b in_ready=%b sum=%h expected 0 1 0000", out_valid, in_ready, sum);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_edge: out_valid=%b in_ready=%b sum=%h cout=%b expected 0 1 0000 0",
                     out_valid, in_ready, sum, cout);
        end
        @(negedge clk) rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_result: out_valid=%b expected 0", out_valid);
            end
        end
        send(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc != 4 || {ovf, cout, sum} !== {2'b01, 16'hFFFF}) begin
            errors++;
            $display("FAIL reset_mid_follow: got ovf=%b cout=%b sum=%h lat=%0d expected 0 1 ffff lat=4",
                     ovf, cout, sum, cyc);
        end
        $display("reset_mid: follow-up sum=%h cout=%b ovf=%b", sum, cout, ovf);
        drain();
    endtask

    task automatic test_width4;
        logic [3:0]  x, y;
        logic        c;
        logic [5:0]  exp_v;
        int cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                x = 4'h9; y = 4'h8; c = 1'b0;
            end else begin
                x = 4'($urandom); y = 4'($urandom); c = 1'($urandom);
            end
            exp_v = model4(x, y, c);
            @(negedge clk);
            a4 = x; b4 = y; cin4 = c; in_valid4 = 1'b1;
            @(posedge clk);
            #1 in_valid4 = 1'b0;
            cyc = 0;
            while (!out_valid4 && cyc < 20) begin
                @(posedge clk);
                #1 cyc++;
            end
            checks++;
            if (cyc != 1 || {ovf4, cout4, sum4} !== exp_v || (i == 0 && exp_v !== {2'b11, 4'h1})) begin
                errors++;
                $display("FAIL width4[%0d]: got ovf=%b cout=%b sum=%h lat=%0d expected ovf=%b cout=%b sum=%h lat=1",
                         i, ovf4, cout4, sum4, cyc, exp_v[5], exp_v[4], exp_v[3:0]);
            end
            $display("width4 %h+%h+%b -> sum=%h cout=%b ovf=%b", x, y, c, sum4, cout4, ovf4);
            @(negedge clk) out_ready4 = 1'b1;
            @(posedge clk);
            #1 out_ready4 = 1'b0;
        end
    endtask

    initial begin
        in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        rst = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder. It accepts full-width operands over a valid/ready handshake and streams them 4 bits per cycle through one 4-bit carry-lookahead adder. The carry is held in a register between nibbles. It returns the full sum, carry-out and signed overflow over a second valid/ready handshake. It sits upstream of the 4-bit CLA and feeds it one nibble slice per cycle. It is the area-cheap wide adder for datapaths that tolerate WIDTH/4 cycles of latency.

Parameters:
- WIDTH, 16, operand/sum width in bits.
  - Must be a multiple of 4 and at least 4; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, nibble counter=0, carry register=0. in_ready=1 after reset.
- Reset asserted mid-operation: abandon the operation immediately. No result is produced for it.
- Constant: NIBBLES = WIDTH/4.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture a and b into shift registers, cin into the carry register, and a[WIDTH-1], b[WIDTH-1] into the sign registers. Clear the counter. Go to RUN.
- State RUN (exactly NIBBLES cycles):
  - in_ready=0, out_valid=0.
  - Each cycle, feed the low nibbles of the A and B shift registers plus the carry register to the CLA.
  - Shift the CLA s output into the top of the sum shift register; the sum register right-shifts by 4.
  - Shift the operand registers right by 4, load the carry register with CLA cout, and increment the counter.
  - After the cycle with counter==NIBBLES-1, go to DONE.
- State DONE:
  - out_valid=1.
  - sum = the assembled sum register.
  - cout = the carry register.
  - ovf = (signA==signB) && (sum[WIDTH-1]!=signA).
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - On out_ready=1 go to IDLE.
  - If in_valid=1 in the same cycle, capture the new operands and go directly to RUN (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational out_ready->in_ready path and is allowed.
- Latency: operands accepted at clock edge E0 give out_valid=1 after edge E0+NIBBLES.
  - Throughput is one operation per NIBBLES+1 cycles under continuous ready.
- sum, cout and ovf hold their last values after the handshake, until the next result is loaded. They carry no meaning while out_valid=0.
- Inputs a, b and cin are ignored outside an accepting cycle. Changing them during RUN has no effect.
- WIDTH=4: RUN lasts 1 cycle.
- The counter width is clog2(NIBBLES), minimum 1 bit. It wraps only via the reset to 0 on capture.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}.
  - constant NIBBLE_W=4.
  - function computing counter width from WIDTH.
- Sub-module: one instance of the codebase's existing 4-bit carry-lookahead adder CLA. Ports: a[3:0], b[3:0], cin → s[3:0], cout. Purely combinational; no other sub-modules.
- FSM, shift registers and handshake logic all live in nibble_serial_adder.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accepting edge.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Checks carry propagation across all 4 nibble cycles.
- a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum, cout, ovf and out_valid stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (a=0x0F0F, b=0xF0F0, cin=1) → same-cycle accept.
  - Next result sum=0x0000, cout=1, ovf=0, 4 cycles later.
- Assert rst during the 2nd RUN cycle → next edge shows IDLE, out_valid=0, sum=0, in_ready=1. A following op a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0.
- WIDTH=4 build: a=0x9, b=0x8, cin=0 → sum=0x1, cout=1, ovf=1, one cycle after accept.
